// File: rtl/led_scan_pkg.sv
// Shared constants, scan state encoding and pixel indexing for the RGB LED matrix scanner.
package led_scan_pkg;

  localparam int LED_ROWS   = 5;
  localparam int LED_COLS   = 5;
  localparam int LED_PIXELS = 25;

  typedef enum logic {
    BLANK = 1'b0,
    ON    = 1'b1
  } scan_state_t;

  function automatic logic [4:0] pix_idx(input logic [2:0] row, input logic [2:0] col);
    return 5'(int'(row) * LED_COLS + int'(col));
  endfunction

  // Phase counter must hold max(blank, dwell) - 1; never narrower than one bit.
  function automatic int cnt_width(input int blank_cycles, input int dwell_cycles);
    int m;
    m = (blank_cycles > dwell_cycles) ? blank_cycles : dwell_cycles;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/led_matrix_scanner_if.sv
// Pixel-word / matrix-pin bundle between the PIO exports and the scanner.
// brightness exists only when LED_SCAN_PWM_EN is defined.
interface led_matrix_scanner_if;
  logic        enable;
  logic [24:0] R;
  logic [24:0] G;
  logic [24:0] B;
`ifdef LED_SCAN_PWM_EN
  logic [7:0]  brightness;
`endif
  logic [4:0]  row_sel;
  logic [4:0]  col_r;
  logic [4:0]  col_g;
  logic [4:0]  col_b;
  logic        frame_start;

`ifdef LED_SCAN_PWM_EN
  modport master (output enable, R, G, B, brightness,
                  input  row_sel, col_r, col_g, col_b, frame_start);
  modport slave  (input  enable, R, G, B, brightness,
                  output row_sel, col_r, col_g, col_b, frame_start);
`else
  modport master (output enable, R, G, B,
                  input  row_sel, col_r, col_g, col_b, frame_start);
  modport slave  (input  enable, R, G, B,
                  output row_sel, col_r, col_g, col_b, frame_start);
`endif
endinterface

// File: rtl/led_scan_timer.sv
// Row-scan sequencer: BLANK/ON state machine, phase counter and row index.
// latch_o marks the first BLANK cycle of row 0 while enabled (frame boundary).
module led_scan_timer
  import led_scan_pkg::*;
#(
  parameter int BLANK_CYCLES = 16,
  parameter int DWELL_CYCLES = 1024,
  localparam int CNT_W = cnt_width(BLANK_CYCLES, DWELL_CYCLES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable_i,
  output scan_state_t       state_o,
  output logic [2:0]        row_o,
  output logic [CNT_W-1:0]  cnt_o,
  output logic              latch_o
);

  scan_state_t      state_q, state_d;
  logic [2:0]       row_q, row_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BLANK;
      row_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    cnt_d   = cnt_q + 1'b1;
    if (!enable_i) begin
      // Parked at the frame boundary so re-enable starts with a fresh latch.
      state_d = BLANK;
      row_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        BLANK: begin
          if (cnt_q == CNT_W'(BLANK_CYCLES - 1)) begin
            state_d = ON;
            cnt_d   = '0;
          end
        end
        ON: begin
          if (cnt_q == CNT_W'(DWELL_CYCLES - 1)) begin
            state_d = BLANK;
            cnt_d   = '0;
            row_d   = (row_q == 3'(LED_ROWS - 1)) ? 3'd0 : row_q + 3'd1;
          end
        end
        default: begin
          state_d = BLANK;
          row_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    state_o = state_q;
    row_o   = row_q;
    cnt_o   = cnt_q;
    latch_o = enable_i && (state_q == BLANK) && (row_q == 3'd0) && (cnt_q == '0);
  end

endmodule

// File: rtl/led_matrix_scanner.sv
// 5x5 common-row RGB LED matrix driver with blanking and frame-boundary shadow latch.
// Optional global PWM brightness when LED_SCAN_PWM_EN is defined.
module led_matrix_scanner
  import led_scan_pkg::*;
#(
  parameter int BLANK_CYCLES = 16,
  parameter int DWELL_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  led_matrix_scanner_if.slave  bus
);

  localparam int CNT_W = cnt_width(BLANK_CYCLES, DWELL_CYCLES);

  scan_state_t      state;
  logic [2:0]       row;
  logic [CNT_W-1:0] cnt;
  logic             latch;

  led_scan_timer #(
    .BLANK_CYCLES (BLANK_CYCLES),
    .DWELL_CYCLES (DWELL_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rst      (reset),
    .enable_i (bus.enable),
    .state_o  (state),
    .row_o    (row),
    .cnt_o    (cnt),
    .latch_o  (latch)
  );

  logic [LED_PIXELS-1:0] shadow_r_q, shadow_r_d;
  logic [LED_PIXELS-1:0] shadow_g_q, shadow_g_d;
  logic [LED_PIXELS-1:0] shadow_b_q, shadow_b_d;
  logic [4:0]            row_sel_q, row_sel_d;
  logic [4:0]            col_r_q, col_r_d;
  logic [4:0]            col_g_q, col_g_d;
  logic [4:0]            col_b_q, col_b_d;
  logic                  frame_start_q, frame_start_d;
  logic                  gate;

`ifdef LED_SCAN_PWM_EN
  assign gate = (8'(cnt) < bus.brightness);
`else
  wire unused_cnt = ^cnt;
  assign gate = 1'b1;
`endif

  always_comb begin
    shadow_r_d    = shadow_r_q;
    shadow_g_d    = shadow_g_q;
    shadow_b_d    = shadow_b_q;
    row_sel_d     = '0;
    col_r_d       = '0;
    col_g_d       = '0;
    col_b_d       = '0;
    frame_start_d = latch;
    if (latch) begin
      shadow_r_d = bus.R;
      shadow_g_d = bus.G;
      shadow_b_d = bus.B;
    end
    // Drive pins only while lit and enabled; everything else is dark.
    if (bus.enable && (state == ON)) begin
      row_sel_d = 5'b00001 << row;
      for (int c = 0; c < LED_COLS; c++) begin
        col_r_d[c] = shadow_r_q[pix_idx(row, 3'(c))] & gate;
        col_g_d[c] = shadow_g_q[pix_idx(row, 3'(c))] & gate;
        col_b_d[c] = shadow_b_q[pix_idx(row, 3'(c))] & gate;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_r_q    <= '0;
      shadow_g_q    <= '0;
      shadow_b_q    <= '0;
      row_sel_q     <= '0;
      col_r_q       <= '0;
      col_g_q       <= '0;
      col_b_q       <= '0;
      frame_start_q <= 1'b0;
    end else begin
      shadow_r_q    <= shadow_r_d;
      shadow_g_q    <= shadow_g_d;
      shadow_b_q    <= shadow_b_d;
      row_sel_q     <= row_sel_d;
      col_r_q       <= col_r_d;
      col_g_q       <= col_g_d;
      col_b_q       <= col_b_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign bus.row_sel     = row_sel_q;
  assign bus.col_r       = col_r_q;
  assign bus.col_g       = col_g_q;
  assign bus.col_b       = col_b_q;
  assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Bench for led_matrix_scanner: time-position reference model of the scan plus directed scenarios.
// Builds with or without LED_SCAN_PWM_EN.
module tb_led_matrix_scanner;
  import led_scan_pkg::*;

`ifdef LED_SCAN_PWM_EN
  localparam int BLANK = 2;
  localparam int DWELL = 256;
`else
  localparam int BLANK = 2;
  localparam int DWELL = 4;
`endif
  localparam int ROWP  = BLANK + DWELL;
  localparam int FRAME = 5 * ROWP;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [24:0] r_in, g_in, b_in;
  logic        en_in;
`ifdef LED_SCAN_PWM_EN
  logic [7:0]  bright_in;
`endif

  led_matrix_scanner_if bus();
  assign bus.enable = en_in;
  assign bus.R      = r_in;
  assign bus.G      = g_in;
  assign bus.B      = b_in;
`ifdef LED_SCAN_PWM_EN
  assign bus.brightness = bright_in;
`endif

  led_matrix_scanner #(
    .BLANK_CYCLES (BLANK),
    .DWELL_CYCLES (DWELL)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // pos = cycles since the latch edge of the current frame (0 = latch edge).
  int          pos = 0;
  int          cyc = 0;
  int          last_fs = -1;
  logic [24:0] m_r = '0, m_g = '0, m_b = '0;
  logic        m_lit = 1'b0;
  int          m_row = 0;
  logic [4:0]  exp_row, exp_cr, exp_cg, exp_cb;
  logic        exp_fs;

  task automatic step();
    int   seg;
    logic gate;
    @(posedge clk);
    cyc++;
    exp_row = '0; exp_cr = '0; exp_cg = '0; exp_cb = '0; exp_fs = 1'b0;
    m_lit = 1'b0;
    if (reset || !en_in) begin
      pos = 0;
      last_fs = -1;
    end else begin
      if (pos == 0) begin
        m_r = r_in; m_g = g_in; m_b = b_in;
      end
      exp_fs = (pos == 0);
      seg    = pos % ROWP;
      m_row  = pos / ROWP;
      m_lit  = (seg >= BLANK);
      gate   = 1'b1;
`ifdef LED_SCAN_PWM_EN
      gate   = ((seg - BLANK) % 256) < int'(bright_in);
`endif
      if (m_lit) begin
        exp_row = 5'b00001 << m_row;
        if (gate) begin
          exp_cr = m_r[m_row*5 +: 5];
          exp_cg = m_g[m_row*5 +: 5];
          exp_cb = m_b[m_row*5 +: 5];
        end
      end
      pos = (pos + 1) % FRAME;
    end
    #1;
    check_eq("row_sel", 32'(bus.row_sel), 32'(exp_row));
    check_eq("col_r", 32'(bus.col_r), 32'(exp_cr));
    check_eq("col_g", 32'(bus.col_g), 32'(exp_cg));
    check_eq("col_b", 32'(bus.col_b), 32'(exp_cb));
    check_eq("frame_start", 32'(bus.frame_start), 32'(exp_fs));
    if (bus.frame_start === 1'b1) begin
      if (last_fs >= 0) check_eq("fs_spacing", 32'(cyc - last_fs), 32'(FRAME));
      last_fs = cyc;
    end
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  // Step until the model says the given row is lit; bounded by two frames.
  task automatic wait_lit(input int row);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      step();
      if (m_lit && m_row == row) found = 1'b1;
    end
    check_eq("wait_lit", 32'(found), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cnt_hi;
    r_in = 25'h0000001; g_in = '0; b_in = '0; en_in = 1'b1;
`ifdef LED_SCAN_PWM_EN
    bright_in = 8'd255;
`endif
    reset = 1'b1;

    // Reset held, outputs dark
    run(3);
    reset = 1'b0;
    run(2 * FRAME);

    // Row walk with all green
    g_in = 25'h1FFFFFF;
    run(2 * FRAME + 3);

    // Tearing: B changes in the middle of row 2
    wait_lit(2);
    step();
    b_in = 25'h1000000;
    wait_lit(4);
    check_eq("tear_old", 32'(bus.col_b[4]), 32'd0);
    wait_lit(0);
    wait_lit(4);
    check_eq("tear_new", 32'(bus.col_b[4]), 32'd1);

    // Enable drop during row 3
    wait_lit(3);
    en_in = 1'b0;
    run(5);
    en_in = 1'b1;
    step();
    check_eq("reen_fs", 32'(bus.frame_start), 32'd1);
    run(2);
    check_eq("reen_row0", 32'(bus.row_sel), 32'd1);
    run(FRAME);

    // Randomized pixel words, enable drops (and brightness)
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) r_in = 25'($urandom);
      if ($urandom_range(0, 7) == 0) g_in = 25'($urandom);
      if ($urandom_range(0, 7) == 0) b_in = 25'($urandom);
      en_in = ($urandom_range(0, 31) != 0);
`ifdef LED_SCAN_PWM_EN
      bright_in = 8'($urandom_range(0, 255));
`endif
      step();
    end
    en_in = 1'b1;
    run(FRAME);

    // Async reset mid-ON, checked before the next clock edge
    wait_lit(1);
    #2;
    reset = 1'b1;
    #1;
    check_eq("async_row_sel", 32'(bus.row_sel), 32'd0);
    check_eq("async_col_r", 32'(bus.col_r), 32'd0);
    check_eq("async_col_g", 32'(bus.col_g), 32'd0);
    check_eq("async_col_b", 32'(bus.col_b), 32'd0);
    check_eq("async_fs", 32'(bus.frame_start), 32'd0);
    run(2);
    reset = 1'b0;
    step();
    check_eq("post_reset_fs", 32'(bus.frame_start), 32'd1);
    run(FRAME + 5);

`ifdef LED_SCAN_PWM_EN
    // PWM duty: 64 of 256 lit cycles per row
    r_in = 25'h1FFFFFF;
    bright_in = 8'd64;
    run(FRAME);
    wait_lit(1);
    cnt_hi = (bus.col_r != 0) ? 1 : 0;
    repeat (DWELL - 1) begin
      step();
      if (bus.col_r != 0) cnt_hi++;
    end
    check_eq("pwm_duty64", 32'(cnt_hi), 32'd64);
    bright_in = 8'd0;
    wait_lit(2);
    cnt_hi = (bus.col_r != 0) ? 1 : 0;
    repeat (DWELL - 1) begin
      step();
      if (bus.col_r != 0) cnt_hi++;
    end
    check_eq("pwm_duty0", 32'(cnt_hi), 32'd0);
`else
    cnt_hi = 0;
    r_in = 25'h1FFFFFF;
    run(FRAME);
    wait_lit(1);
    repeat (DWELL) begin
      if (bus.col_r == 5'b11111) cnt_hi++;
      step();
    end
    check_eq("full_dwell", 32'(cnt_hi), 32'(DWELL));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/led_matrix_scanner.md
# led_matrix_scanner

Sink-side driver for the Nios RGB LED PIO exports. It takes the three 25-bit red/green/blue PIO words and drives a 5x5 common-row RGB LED matrix by time-multiplexed row scanning, with anti-ghost blanking between rows. Frames are latched at frame boundaries so software writes never tear mid-frame. It sits in the top level between the Qsys system's `red_led`/`green_led`/`blue_led` exports and the board pins.

## Interface
- `BLANK_CYCLES`, default 16: all-off cycles before each row is lit (≥1).
- `DWELL_CYCLES`, default 1024: lit cycles per row (≥1; ≥256 when `LED_SCAN_PWM_EN` is defined).
- `clk` in 1: system clock, the same clock as the Qsys `clk_clk`.
- `reset` in 1: asynchronous, active-high reset.
- `enable` in 1: scanning enable; low forces the matrix dark.
- `R` in 25: red pixel word; bit index = row*5 + col.
- `G` in 25: green pixel word, same indexing.
- `B` in 25: blue pixel word, same indexing.
- `brightness` in 8: global duty. The port exists only with `LED_SCAN_PWM_EN`.
- `row_sel` out 5: one-hot row drive, active-high.
- `col_r` out 5: red column drive for the lit row, active-high.
- `col_g` out 5: green column drive, active-high.
- `col_b` out 5: blue column drive, active-high.
- `frame_start` out 1: one-cycle pulse when a new frame is latched.

## Operation
- **State machine:** two states, BLANK and ON. It also holds a 3-bit row index (0..4) and a phase counter sized for max(BLANK_CYCLES, DWELL_CYCLES).
- **BLANK:**
  - `row_sel`, `col_*` = 0.
  - The counter runs 0..BLANK_CYCLES-1, then the block enters ON with the counter at 0.
- **ON:**
  - `row_sel[row]` = 1.
  - `col_x[c]` = shadow_x[row*5+c].
  - The counter runs 0..DWELL_CYCLES-1, then the block enters BLANK.
  - On that exit the row increments, wrapping from 4 to 0.
- **Frame latch:**
  - Trigger: the first cycle of BLANK for row 0.
  - Action: shadow_R/G/B <= R/G/B, and `frame_start` pulses in that cycle.
  - R/G/B changes at any other time are invisible until the next latch.
- **enable low:**
  - On the next edge the block goes to BLANK, row 0, counter 0, and outputs go 0.
  - This holds while `enable` stays low.
  - No `frame_start` pulses while `enable` is low.
  - On the first cycle with `enable` high, the block starts at BLANK row 0 counter 0, latches the shadow and pulses `frame_start`.
- **Reset:**
  - Outputs: `row_sel`, `col_r/g/b`, `frame_start` = 0.
  - State: BLANK, row 0, counter 0, shadows 0.
  - Frame latch: as defined above, the first cycle after reset release is a latch cycle.
  - Mid-scan reset: an asserted reset aborts any row immediately and asynchronously.
- **Pixel mapping:** bit 0 is row 0 col 0; bit 24 is row 4 col 4. There is no inversion.

## Timing
- **Registered outputs:** all outputs are registered, so they change only on `clk` rising edges (or on async reset).
- **Row period:** BLANK_CYCLES + DWELL_CYCLES.
- **Frame period:** 5 × (BLANK_CYCLES + DWELL_CYCLES). With the defaults this is 5200 cycles, about 9.6 kHz at 50 MHz.
- **R/G/B → pins latency:**
  - The shadow captures R/G/B on the latch edge.
  - Row 0 lights BLANK_CYCLES cycles after that edge.
  - A pixel in row r lights r × (BLANK_CYCLES+DWELL_CYCLES) cycles later still.
- **`frame_start` spacing:** exactly one frame period apart during continuous scanning.
- **Row overlap:** `row_sel` is never multi-hot. Any two lit rows are separated by at least BLANK_CYCLES cycles of zero.
- **Column enables:** `col_*` is never nonzero while `row_sel` = 0.

## Configuration
- **`LED_SCAN_PWM_EN` defined:**
  - The `brightness` port exists.
  - During ON, `col_x[c]` = shadow bit AND (counter[7:0] < `brightness`).
  - `brightness` = 0 keeps the matrix dark; 255 gives 255/256 duty within each 256-cycle slice.
  - `brightness` is sampled every cycle, not latched.
- **`LED_SCAN_PWM_EN` undefined:**
  - There is no `brightness` port.
  - Columns are on for the full dwell.

## Structure
- **Package `led_scan_pkg`:**
  - `LED_ROWS` = 5, `LED_COLS` = 5, `LED_PIXELS` = 25.
  - State enum `scan_state_t` {BLANK, ON}.
  - Helper function `pix_idx(row, col)`.
- **Sub-module `led_scan_timer`:**
  - Contents: the phase counter, the state machine and the row index.
  - Outputs: state, row, counter and the latch strobe.
  - The top instantiates it and adds the shadow registers, column extraction and PWM gate.

## Test plan
- **Reset:** BLANK_CYCLES=2, DWELL_CYCLES=4, `enable`=1, R=25'h0000001, reset held 3 cycles → while in reset, all outputs 0. After release:
  - `frame_start`=1 on the first edge.
  - `row_sel`=5'b00001 and `col_r`=5'b00001 from cycle 2 to cycle 5.
  - All outputs 0 on cycles 6–7.
- **Row walk:** G=25'h1FFFFFF → `row_sel` walks 00001, 00010, 00100, 01000, 10000, 00001 with a period of 6 cycles. `col_g`=5'b11111 in each ON window. `frame_start` repeats every 30 cycles.
- **Tearing:** change B from 0 to 25'h1000000 in the middle of row 2 → `col_b[4]` stays 0 for row 4 of the current frame and is 1 in row 4 of the next frame.
- **Enable drop:** deassert `enable` during row 3 ON → the next cycle all outputs are 0 and no `frame_start` pulses. After re-enable, `frame_start` pulses in the first enabled cycle and row 0 lights 2 cycles later.
- **PWM:** with `LED_SCAN_PWM_EN`, DWELL_CYCLES=256, `brightness`=64, R=25'h1FFFFFF → `col_r` is high for exactly 64 of the 256 ON cycles per row. With `brightness`=0, `col_r` is always 0.
- **Async reset mid-ON:** assert `reset` mid-ON → all outputs go 0 without waiting for a clock edge.
